// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding, frame layout
// constants and state-class helpers.
package program_loader_pkg;

   localparam int DEF_ADDR_W     = 11;
   localparam int DEF_DATA_W     = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 16;

   // Enum order follows the frame field order: length bytes, payload, checksum.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_WORD   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_RUN    = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   function automatic logic takes_byte(input state_t s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_WORD) || (s == ST_CHECK);
   endfunction

   function automatic logic in_frame(input state_t s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_WORD) ||
             (s == ST_WRITE)  || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches CYCLES-1.
module loader_timeout #(
   parameter int CYCLES = 1000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] r_cnt;

   // Idle counter, saturating at the expiry value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CW'(CYCLES - 1))) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_expired = i_en && (r_cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes 32-bit words
// into instruction memory and releases the CPU once the checksum verifies.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int BASE_ADRS      = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load_req,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [DATA_W-1:0] w_instruction,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_adrs,
   output logic              cpu_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int MAX_WORDS = 1 << ADDR_W;

   state_t            r_state, w_next_state;
   logic [LEN_W-1:0]  r_len, r_idx;
   logic [1:0]        r_byte_cnt;
   logic [DATA_W-9:0] r_shift;
   logic [7:0]        r_chk;

   logic              r_rx_ready, r_w_enable, r_cpu_en, r_busy, r_done, r_error;
   logic [DATA_W-1:0] r_w_instruction;
   logic [ADDR_W-1:0] r_w_adrs;

   logic              w_rx_ready, w_w_enable, w_cpu_en, w_busy, w_done, w_error;
   logic              w_accept, w_expired, w_tmo_clr;
   logic [LEN_W-1:0]  w_len_n;
   logic [DATA_W-1:0] w_word;
   logic [ADDR_W-1:0] w_adrs_n;

   assign w_accept  = rx_valid && r_rx_ready;
   assign w_len_n   = {rx_data, r_len[7:0]};
   assign w_word    = {rx_data, r_shift};
   assign w_adrs_n  = ADDR_W'(BASE_ADRS) + r_idx[ADDR_W-1:0];
   assign w_tmo_clr = w_accept || load_req || (w_next_state != r_state);

   loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk       (clk),
      .resetn    (resetn),
      .i_clr     (w_tmo_clr),
      .i_en      (in_frame(r_state)),
      .o_expired (w_expired)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; load_req overrides everything, including a same-cycle byte.
   always_comb begin
      w_next_state = r_state;
      if (load_req) begin
         w_next_state = ST_LEN_LO;
      end else begin
         case (r_state)
            ST_LEN_LO: begin
               if (w_accept)       w_next_state = ST_LEN_HI;
               else if (w_expired) w_next_state = ST_ERR;
               else                w_next_state = ST_LEN_LO;
            end
            ST_LEN_HI: begin
               if (w_accept) begin
                  if (32'(w_len_n) > 32'(MAX_WORDS)) w_next_state = ST_ERR;
                  else if (w_len_n == 16'd0)       w_next_state = ST_CHECK;
                  else                             w_next_state = ST_WORD;
               end else if (w_expired) begin
                  w_next_state = ST_ERR;
               end else begin
                  w_next_state = ST_LEN_HI;
               end
            end
            ST_WORD: begin
               if (w_accept && (r_byte_cnt == 2'd3)) w_next_state = ST_WRITE;
               else if (!w_accept && w_expired)      w_next_state = ST_ERR;
               else                                  w_next_state = ST_WORD;
            end
            ST_WRITE: begin
               if ((r_idx + 16'd1) == r_len) w_next_state = ST_CHECK;
               else                          w_next_state = ST_WORD;
            end
            ST_CHECK: begin
               if (w_accept)       w_next_state = (rx_data == r_chk) ? ST_RUN : ST_ERR;
               else if (w_expired) w_next_state = ST_ERR;
               else                w_next_state = ST_CHECK;
            end
            ST_IDLE:  w_next_state = ST_IDLE;
            ST_RUN:   w_next_state = ST_RUN;
            ST_ERR:   w_next_state = ST_ERR;
            default:  w_next_state = ST_IDLE;
         endcase
      end
   end

   // Output decode from the upcoming state so every output leaves a flop.
   always_comb begin
      w_rx_ready = takes_byte(w_next_state);
      w_w_enable = (w_next_state == ST_WRITE);
      w_busy     = in_frame(w_next_state);
      w_done     = (w_next_state == ST_RUN);
      w_cpu_en   = (w_next_state == ST_RUN);
      w_error    = (w_next_state == ST_ERR);
   end

   // Registered outputs; word and address are only driven during a write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_ready      <= 1'b0;
         r_w_enable      <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_cpu_en        <= 1'b0;
         r_error         <= 1'b0;
         r_w_instruction <= '0;
         r_w_adrs        <= '0;
      end else begin
         r_rx_ready      <= w_rx_ready;
         r_w_enable      <= w_w_enable;
         r_busy          <= w_busy;
         r_done          <= w_done;
         r_cpu_en        <= w_cpu_en;
         r_error         <= w_error;
         r_w_instruction <= w_w_enable ? w_word : '0;
         r_w_adrs        <= w_w_enable ? w_adrs_n : '0;
      end
   end

   // Frame datapath: length capture, LSB-first word assembly, running checksum.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_len      <= '0;
         r_idx      <= '0;
         r_byte_cnt <= 2'd0;
         r_shift    <= '0;
         r_chk      <= 8'd0;
      end else if (load_req) begin
         r_len      <= '0;
         r_idx      <= '0;
         r_byte_cnt <= 2'd0;
         r_shift    <= '0;
         r_chk      <= 8'd0;
      end else begin
         case (r_state)
            ST_LEN_LO: if (w_accept) r_len[7:0] <= rx_data;
            ST_LEN_HI: begin
               if (w_accept) r_len[15:8] <= rx_data;
               r_idx      <= '0;
               r_byte_cnt <= 2'd0;
            end
            ST_WORD: begin
               if (w_accept) begin
                  r_shift    <= {rx_data, r_shift[DATA_W-9:8]};
                  r_chk      <= r_chk ^ rx_data;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            ST_WRITE: r_idx <= r_idx + 16'd1;
            default:  r_idx <= r_idx;
         endcase
      end
   end

   assign rx_ready      = r_rx_ready;
   assign w_enable      = r_w_enable;
   assign w_instruction = r_w_instruction;
   assign w_adrs        = r_w_adrs;
   assign cpu_en        = r_cpu_en;
   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;

endmodule
